// File: rtl/intersection_sequencer_if.sv
// Lamp/sensor bundle for the intersection sequencer.
// master drives en, sensors and buttons; slave drives lamps and phase.
interface intersection_sequencer_if;
  logic       en;
  logic       sens_th;
  logic       sens_nn;
  logic       sens_ns;
  logic       btn_th;
  logic       btn_nn;
  logic       btn_ns;
  logic [2:0] th_lamp;
  logic [2:0] n_lamp;
  logic [1:0] turn_th;
  logic [1:0] turn_nn;
  logic [1:0] ped_lamp;
  logic [2:0] phase;

  modport master (
    output en, sens_th, sens_nn, sens_ns,
    output btn_th, btn_nn, btn_ns,
    input  th_lamp, n_lamp, turn_th, turn_nn,
    input  ped_lamp, phase
  );

  modport slave (
    input  en, sens_th, sens_nn, sens_ns,
    input  btn_th, btn_nn, btn_ns,
    output th_lamp, n_lamp, turn_th, turn_nn,
    output ped_lamp, phase
  );
endinterface

// File: rtl/intersection_sequencer.sv
// Demand-actuated phase controller for a four-way intersection.
// Ports: CLK, async active-low reset, io (slave): en/sensors/buttons in, lamps/phase out.
module intersection_sequencer #(
  parameter int TICKS_PER_MS = 10,
  parameter int T_ALLRED     = 2000,
  parameter int T_YELLOW     = 3000,
  parameter int T_MIN_GREEN  = 10000,
  parameter int T_MAX_GREEN  = 40000,
  parameter int T_WALK       = 8000,
  parameter int T_FLASH      = 500
) (
  input  logic                     CLK,
  input  logic                     reset,
  intersection_sequencer_if.slave  io
);

  typedef enum logic [2:0] {
    ALLRED    = 3'd0,
    TH_GREEN  = 3'd1,
    TH_YELLOW = 3'd2,
    N_GREEN   = 3'd3,
    N_YELLOW  = 3'd4,
    PED_WALK  = 3'd5,
    FLASH     = 3'd6
  } state_e;

  localparam int PW =
    (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(TICKS_PER_MS - 1);
  localparam logic [15:0] ALLRED_T = 16'(T_ALLRED);
  localparam logic [15:0] YEL_T    = 16'(T_YELLOW);
  localparam logic [15:0] MIN_T    = 16'(T_MIN_GREEN);
  localparam logic [15:0] MAX_T    = 16'(T_MAX_GREEN);
  localparam logic [15:0] WALK_T   = 16'(T_WALK);
  localparam logic [15:0] FLASH_T  = 16'(T_FLASH);

  // bit 6 = en, 5..3 = sensors th/nn/ns, 2..0 = buttons.
  // en syncs out of reset as enabled so a clean
  // reset begins in ALLRED rather than FLASH.
  localparam logic [6:0] SYNC_RST = 7'b100_0000;

  logic [6:0]    sync1_q, sync2_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   elapsed_q, elapsed_d;
  logic [15:0]   elapsed_n;
  state_e        state_q, state_d;
  logic          ped_req_q, ped_req_d;
  logic          last_q, last_d;
  logic          from_walk_q, from_walk_d;
  logic          flash_on_q, flash_on_d;
  logic [2:0]    th_lamp_q, th_lamp_d;
  logic [2:0]    n_lamp_q, n_lamp_d;
  logic [1:0]    turn_th_q, turn_th_d;
  logic [1:0]    turn_nn_q, turn_nn_d;
  logic [1:0]    ped_lamp_q, ped_lamp_d;

  logic en_s, th_s, nn_s, ns_s, btn_any;
  logic ms_tick, restart;
  logic cross_th, cross_n;
  logic walk_entry;

  assign en_s    = sync2_q[6];
  assign th_s    = sync2_q[5];
  assign nn_s    = sync2_q[4];
  assign ns_s    = sync2_q[3];
  assign btn_any = |sync2_q[2:0];

  assign ms_tick = (presc_q == PRE_MAX);
  assign presc_d = ms_tick ? '0 : presc_q + PW'(1);

  // Elapsed value as of the coming edge; timed
  // exits fire on the edge that reaches T, so a
  // state lasts exactly T ticks.
  assign elapsed_n =
    (ms_tick && elapsed_q != 16'hFFFF)
      ? elapsed_q + 16'd1 : elapsed_q;

  assign cross_th = nn_s | ns_s | ped_req_q;
  assign cross_n  = th_s | ped_req_q;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    from_walk_d = from_walk_q;
    flash_on_d  = flash_on_q;
    restart     = 1'b0;
    if (!en_s) begin
      if (state_q != FLASH) begin
        state_d    = FLASH;
        flash_on_d = 1'b1;
      end else if (elapsed_n == FLASH_T) begin
        flash_on_d = ~flash_on_q;
        restart    = 1'b1;
      end
    end else begin
      unique case (state_q)
        ALLRED: begin
          if (elapsed_n == ALLRED_T) begin
            if (ped_req_q && !from_walk_q)
              state_d = PED_WALK;
            else if (!last_q)
              state_d = N_GREEN;
            else
              state_d = TH_GREEN;
          end
        end
        TH_GREEN: begin
          if (cross_th &&
              ((elapsed_n >= MIN_T && !th_s) ||
               elapsed_n >= MAX_T))
            state_d = TH_YELLOW;
        end
        TH_YELLOW: begin
          if (elapsed_n == YEL_T)
            state_d = ALLRED;
        end
        N_GREEN: begin
          if (cross_n &&
              ((elapsed_n >= MIN_T && !nn_s && !ns_s) ||
               elapsed_n >= MAX_T))
            state_d = N_YELLOW;
        end
        N_YELLOW: begin
          if (elapsed_n == YEL_T)
            state_d = ALLRED;
        end
        PED_WALK: begin
          if (elapsed_n == WALK_T)
            state_d = ALLRED;
        end
        FLASH: begin
          state_d = ALLRED;
          last_d  = 1'b1;
        end
        default: state_d = ALLRED;
      endcase
    end
    if (state_d != state_q)
      restart = 1'b1;
    if (state_d == TH_GREEN && state_q != TH_GREEN)
      last_d = 1'b0;
    if (state_d == N_GREEN && state_q != N_GREEN)
      last_d = 1'b1;
    if (state_d == ALLRED && state_q != ALLRED)
      from_walk_d = (state_q == PED_WALK);
  end

  assign elapsed_d = restart ? 16'd0 : elapsed_n;

  // A button seen on the walk-entry edge keeps the
  // request alive.
  assign walk_entry =
    (state_d == PED_WALK) && (state_q != PED_WALK);
  assign ped_req_d =
    btn_any | (ped_req_q & ~walk_entry);

  always_comb begin
    th_lamp_d  = 3'b001;
    n_lamp_d   = 3'b001;
    turn_th_d  = 2'b01;
    turn_nn_d  = 2'b01;
    ped_lamp_d = 2'b01;
    unique case (state_d)
      TH_GREEN: begin
        th_lamp_d = 3'b100;
        turn_th_d = 2'b10;
      end
      TH_YELLOW: th_lamp_d = 3'b010;
      N_GREEN: begin
        n_lamp_d  = 3'b100;
        turn_nn_d = 2'b10;
      end
      N_YELLOW: n_lamp_d   = 3'b010;
      PED_WALK: ped_lamp_d = 2'b10;
      FLASH: begin
        th_lamp_d = {1'b0, flash_on_d, 1'b0};
        n_lamp_d  = {1'b0, flash_on_d, 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1_q     <= SYNC_RST;
      sync2_q     <= SYNC_RST;
      presc_q     <= '0;
      elapsed_q   <= '0;
      state_q     <= ALLRED;
      ped_req_q   <= 1'b0;
      last_q      <= 1'b1;
      from_walk_q <= 1'b0;
      flash_on_q  <= 1'b0;
      th_lamp_q   <= 3'b001;
      n_lamp_q    <= 3'b001;
      turn_th_q   <= 2'b01;
      turn_nn_q   <= 2'b01;
      ped_lamp_q  <= 2'b01;
    end else begin
      sync1_q     <= {io.en, io.sens_th,
                      io.sens_nn, io.sens_ns,
                      io.btn_th, io.btn_nn,
                      io.btn_ns};
      sync2_q     <= sync1_q;
      presc_q     <= presc_d;
      elapsed_q   <= elapsed_d;
      state_q     <= state_d;
      ped_req_q   <= ped_req_d;
      last_q      <= last_d;
      from_walk_q <= from_walk_d;
      flash_on_q  <= flash_on_d;
      th_lamp_q   <= th_lamp_d;
      n_lamp_q    <= n_lamp_d;
      turn_th_q   <= turn_th_d;
      turn_nn_q   <= turn_nn_d;
      ped_lamp_q  <= ped_lamp_d;
    end
  end

  assign io.th_lamp  = th_lamp_q;
  assign io.n_lamp   = n_lamp_q;
  assign io.turn_th  = turn_th_q;
  assign io.turn_nn  = turn_nn_q;
  assign io.ped_lamp = ped_lamp_q;
  assign io.phase    = state_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Scoreboard bench for intersection_sequencer.
// Stimulus queues expected output changes; a negedge monitor checks them.
module tb_intersection_sequencer;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] th;
    logic [2:0] n;
    logic [1:0] tt;
    logic [1:0] tn;
    logic [1:0] ped;
  } out_t;

  typedef struct {
    out_t o;
    int   dur;
  } exp_t;

  localparam out_t O_AR   = {3'd0, 3'b001, 3'b001, 2'b01, 2'b01, 2'b01};
  localparam out_t O_THG  = {3'd1, 3'b100, 3'b001, 2'b10, 2'b01, 2'b01};
  localparam out_t O_THY  = {3'd2, 3'b010, 3'b001, 2'b01, 2'b01, 2'b01};
  localparam out_t O_NG   = {3'd3, 3'b001, 3'b100, 2'b01, 2'b10, 2'b01};
  localparam out_t O_NY   = {3'd4, 3'b001, 3'b010, 2'b01, 2'b01, 2'b01};
  localparam out_t O_PW   = {3'd5, 3'b001, 3'b001, 2'b01, 2'b01, 2'b10};
  localparam out_t O_FON  = {3'd6, 3'b010, 3'b010, 2'b01, 2'b01, 2'b01};
  localparam out_t O_FOFF = {3'd6, 3'b000, 3'b000, 2'b01, 2'b01, 2'b01};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  intersection_sequencer_if io();

  intersection_sequencer #(
    .TICKS_PER_MS(1),
    .T_ALLRED(4),
    .T_YELLOW(3),
    .T_MIN_GREEN(10),
    .T_MAX_GREEN(20),
    .T_WALK(6),
    .T_FLASH(2)
  ) dut (
    .CLK(clk),
    .reset(rst_n),
    .io(io)
  );

  int   total = 0;
  int   bad = 0;
  bit   mon_on = 1'b0;
  exp_t q[$];
  exp_t e;
  out_t cur_o;
  out_t last_o;
  int   cnt = 0;

  assign cur_o = {io.phase, io.th_lamp, io.n_lamp,
                  io.turn_th, io.turn_nn, io.ped_lamp};

  task automatic push(input out_t o, input int d);
    exp_t x;
    x.o = o;
    x.dur = d;
    q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (io.phase !== p && n < 400);
    total++;
    if (io.phase !== p) begin
      bad++;
      $display("FAIL wait_phase got=%0d want=%0d", io.phase, p);
    end
  endtask

  // Monitor: every change of the output vector pops one
  // expectation and checks the new value and how many
  // cycles the previous value was held.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_on) begin
        last_o = cur_o;
        cnt = 0;
      end else begin
        if (cur_o !== last_o) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change got=%h", cur_o);
          end else begin
            e = q.pop_front();
            if (cur_o !== e.o ||
                (e.dur >= 0 && cnt != e.dur)) begin
              bad++;
              $display("FAIL seq got=%h held=%0d want=%h held=%0d",
                       cur_o, cnt, e.o, e.dur);
            end
          end
          last_o = cur_o;
          cnt = 1;
        end else begin
          cnt++;
        end
        if (!rst_n) cnt = 0;
      end
    end
  end

  initial begin
    io.en = 1'b1;
    io.sens_th = 1'b0;
    io.sens_nn = 1'b0;
    io.sens_ns = 1'b0;
    io.btn_th = 1'b0;
    io.btn_nn = 1'b0;
    io.btn_ns = 1'b0;
    tick(3);
    chk("rst_phase", 32'(io.phase), 32'd0);
    chk("rst_th", 32'(io.th_lamp), 32'b001);
    chk("rst_n", 32'(io.n_lamp), 32'b001);
    chk("rst_tt", 32'(io.turn_th), 32'b01);
    chk("rst_tn", 32'(io.turn_nn), 32'b01);
    chk("rst_ped", 32'(io.ped_lamp), 32'b01);
    chk("rst_ped_req", 32'(dut.ped_req_q), 32'd0);
    chk("rst_last", 32'(dut.last_q), 32'd1);

    // idle: ALLRED 4 then TH green rests
    mon_on = 1'b1;
    push(O_THG, 4);
    rst_n = 1'b1;
    wait_phase(3'd1);
    tick(100);

    // both roads busy: max-out each way
    push(O_THY, 103);
    push(O_AR, 3);
    push(O_NG, 4);
    push(O_NY, 20);
    push(O_AR, 3);
    push(O_THG, 4);
    push(O_THY, 20);
    push(O_AR, 3);
    push(O_NG, 4);
    io.sens_th = 1'b1;
    io.sens_nn = 1'b1;
    wait_phase(3'd3);
    wait_phase(3'd1);
    wait_phase(3'd3);
    io.sens_th = 1'b0;
    io.sens_nn = 1'b0;

    // button pulse during resting N green
    push(O_NY, 34);
    push(O_AR, 3);
    push(O_PW, 4);
    push(O_AR, 6);
    push(O_THG, 4);
    tick(30);
    io.btn_th = 1'b1;
    tick(1);
    io.btn_th = 1'b0;
    wait_phase(3'd1);

    // held button: one walk per vehicle green
    push(O_THY, 10);
    push(O_AR, 3);
    push(O_PW, 4);
    push(O_AR, 6);
    push(O_NG, 4);
    push(O_NY, 10);
    push(O_AR, 3);
    push(O_PW, 4);
    push(O_AR, 6);
    push(O_THG, 4);
    io.btn_nn = 1'b1;
    wait_phase(3'd3);
    io.btn_nn = 1'b0;
    wait_phase(3'd1);

    // opposing sensor from cycle 2: min-green gap-out
    push(O_THY, 10);
    push(O_AR, 3);
    push(O_NG, 4);
    tick(2);
    io.sens_ns = 1'b1;
    wait_phase(3'd2);
    io.sens_ns = 1'b0;
    wait_phase(3'd3);

    // back to TH, then en drop in TH yellow
    push(O_NY, 10);
    push(O_AR, 3);
    push(O_THG, 4);
    push(O_THY, 10);
    push(O_FON, 3);
    push(O_FOFF, 2);
    push(O_FON, 2);
    push(O_FOFF, 2);
    push(O_AR, 1);
    push(O_THG, 4);
    io.sens_th = 1'b1;
    wait_phase(3'd4);
    io.sens_th = 1'b0;
    wait_phase(3'd1);
    io.sens_ns = 1'b1;
    wait_phase(3'd2);
    io.en = 1'b0;
    io.sens_ns = 1'b0;
    wait_phase(3'd6);
    tick(4);
    io.en = 1'b1;
    wait_phase(3'd1);

    // walk, then async reset in the middle of it
    push(O_THY, 10);
    push(O_AR, 3);
    push(O_PW, 4);
    io.btn_th = 1'b1;
    tick(1);
    io.btn_th = 1'b0;
    wait_phase(3'd5);
    io.btn_ns = 1'b1;
    tick(3);
    chk("walk_ped_req", 32'(dut.ped_req_q), 32'd1);
    #1;
    push(O_AR, -1);
    push(O_THG, 4);
    rst_n = 1'b0;
    #1;
    chk("arst_phase", 32'(io.phase), 32'd0);
    chk("arst_ped", 32'(io.ped_lamp), 32'b01);
    chk("arst_th", 32'(io.th_lamp), 32'b001);
    chk("arst_n", 32'(io.n_lamp), 32'b001);
    chk("arst_ped_req", 32'(dut.ped_req_q), 32'd0);
    io.btn_ns = 1'b0;
    tick(3);
    rst_n = 1'b1;
    wait_phase(3'd1);

    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(negedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
